// File: rtl/uart_rx.sv
// Mid-bit sampling UART receiver, 8N1 by default.
// Defining UART_RX_PARITY_EN adds an even-parity bit between data and stop (8E1).
module uart_rx #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] data,
    output logic       valid,
    output logic       frame_err,
    output logic       busy
);

    localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_RX_PARITY_EN
        PARITY,
`endif
        STOP,
        BRK
    } state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [2:0]    bit_idx, bit_idx_nxt;
    logic [7:0]    shreg, shreg_nxt;
    logic [7:0]    data_nxt;
    logic          valid_nxt, frame_err_nxt;
    logic          rx_m, rx_s;
    logic          par_ok;

    // Two-flop synchronizer; resets to the idle (high) line level.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
        end else begin
            rx_m <= rx;
            rx_s <= rx_m;
        end
    end

`ifdef UART_RX_PARITY_EN
    logic par_bit, par_bit_nxt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) par_bit <= 1'b0;
        else      par_bit <= par_bit_nxt;
    end

    // Even parity: data bits plus parity bit must XOR to zero.
    assign par_ok = ~(par_bit ^ (^shreg));
`else
    assign par_ok = 1'b1;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            cnt       <= '0;
            bit_idx   <= '0;
            shreg     <= '0;
            data      <= '0;
            valid     <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            bit_idx   <= bit_idx_nxt;
            shreg     <= shreg_nxt;
            data      <= data_nxt;
            valid     <= valid_nxt;
            frame_err <= frame_err_nxt;
        end
    end

    // NOTE: every signal gets a default before the case so no latch can be inferred.
    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt + 1'b1;
        bit_idx_nxt   = bit_idx;
        shreg_nxt     = shreg;
        data_nxt      = data;
        valid_nxt     = 1'b0;
        frame_err_nxt = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bit_nxt   = par_bit;
`endif
        unique case (state)
            IDLE: begin
                cnt_nxt = '0;
                if (!rx_s) state_nxt = START;
            end
            START: begin
                if (cnt == CNT_HALF) begin
                    cnt_nxt     = '0;
                    bit_idx_nxt = '0;
                    state_nxt   = rx_s ? IDLE : DATA;
                end
            end
            DATA: begin
                if (cnt == CNT_LAST) begin
                    cnt_nxt     = '0;
                    shreg_nxt   = {rx_s, shreg[7:1]};
                    bit_idx_nxt = bit_idx + 3'd1;
                    if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_nxt = PARITY;
`else
                        state_nxt = STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (cnt == CNT_LAST) begin
                    cnt_nxt     = '0;
                    par_bit_nxt = rx_s;
                    state_nxt   = STOP;
                end
            end
`endif
            STOP: begin
                if (cnt == CNT_LAST) begin
                    cnt_nxt = '0;
                    if (rx_s && par_ok) begin
                        data_nxt  = shreg;
                        valid_nxt = 1'b1;
                        state_nxt = IDLE;
                    end else begin
                        frame_err_nxt = 1'b1;
                        state_nxt     = BRK;
                    end
                end
            end
            BRK: begin
                // A line held low must return high before another start bit is accepted.
                cnt_nxt = '0;
                if (rx_s) state_nxt = IDLE;
            end
            default: begin
                cnt_nxt   = '0;
                state_nxt = IDLE;
            end
        endcase
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: expected strobes are queued as frames are driven
// and compared against valid/frame_err when they appear.
module tb_uart_rx;

    localparam int CPB = 16;
`ifdef UART_RX_PARITY_EN
    localparam int LAT = 171;
`else
    localparam int LAT = 155;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       rx;
    logic [7:0] data;
    logic       valid, frame_err, busy;

    uart_rx #(.CLKS_PER_BIT(CPB)) dut (
        .clk      (clk),
        .rst      (rst),
        .rx       (rx),
        .data     (data),
        .valid    (valid),
        .frame_err(frame_err),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    // cyc = number of rising edges so far; at a negedge the upcoming edge is cyc+1.
    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct {
        bit         err;
        logic [7:0] d;
        int         at;   // upcoming-edge index at which the strobe is seen, 0 = don't care
    } exp_t;

    exp_t       sb[$];
    int         total = 0;
    int         bad   = 0;
    logic [7:0] last_good = 8'h00;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Strobe monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (rst === 1'b1 && (valid === 1'b1 || frame_err === 1'b1)) begin
            check("strobe_excl", 32'(valid & frame_err), 0);
            if (sb.size() == 0) begin
                check("unexpected_strobe", {30'd0, valid, frame_err}, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("strobe_kind", 32'(frame_err), 32'(e.err));
                check("strobe_data", 32'(data), 32'(e.d));
                check("busy_at_strobe", 32'(busy), 32'(e.err));
                if (e.at != 0) check("strobe_latency", cyc + 1, e.at);
            end
        end
    end

    task automatic drive(input logic v);
        rx = v;
        repeat (CPB) @(negedge clk);
    endtask

    // Caller must be at a falling edge; no idle gap is inserted before the start bit.
    task automatic send(input logic [7:0] b, input bit stop, input bit par_flip,
                        input int abort_bit, input int extra_low, input bit timed);
        int e_edge;
        bit err;
        exp_t e;
        e_edge = cyc + 1;
        err = !stop;
`ifdef UART_RX_PARITY_EN
        err = err | par_flip;
`endif
        if (abort_bit < 0) begin
            e.err = err;
            e.d   = err ? last_good : b;
            e.at  = timed ? e_edge + LAT : 0;
            sb.push_back(e);
            if (!err) last_good = b;
        end
        drive(1'b0);
        for (int i = 0; i < 8; i++) begin
            if (i == abort_bit) begin
                rx = b[i];
                repeat (CPB / 2) @(negedge clk);
                rst = 1'b0;
                rx  = 1'b1;
                #1;
                check("rst_data", 32'(data), 0);
                check("rst_valid", 32'(valid), 0);
                check("rst_ferr", 32'(frame_err), 0);
                check("rst_busy", 32'(busy), 0);
                last_good = 8'h00;
                repeat (3) @(negedge clk);
                rst = 1'b1;
                return;
            end
            drive(b[i]);
        end
`ifdef UART_RX_PARITY_EN
        drive((^b) ^ par_flip);
`endif
        drive(stop);
        if (extra_low > 0) begin
            repeat (extra_low) @(negedge clk);
            check("brk_busy_low", 32'(busy), 1);
            rx = 1'b1;
            repeat (4) @(negedge clk);
            check("brk_busy_released", 32'(busy), 0);
        end
    endtask

    task automatic drain(input string tag);
        repeat (6) @(negedge clk);
        check(tag, sb.size(), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        int e_edge;
        logic [7:0] rb;
        rst = 1'b0;
        rx  = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_data", 32'(data), 0);
        check("reset_valid", 32'(valid), 0);
        check("reset_ferr", 32'(frame_err), 0);
        check("reset_busy", 32'(busy), 0);
        rst = 1'b1;
        repeat (5) @(negedge clk);

        // Single byte with exact strobe timing.
        send(8'h41, 1'b1, 1'b0, -1, 0, 1'b1);
        drain("single_pending");

        // Back-to-back frames, no idle gap.
        send(8'h41, 1'b1, 1'b0, -1, 0, 1'b1);
        send(8'h42, 1'b1, 1'b0, -1, 0, 1'b1);
        for (int k = 0; k < 4; k++) begin
            rb = 8'($urandom_range(0, 255));
            send(rb, 1'b1, 1'b0, -1, 0, 1'b1);
        end
        drain("b2b_pending");

        // Glitch: 3 low cycles, START must be abandoned at mid start bit.
        rx = 1'b0;
        e_edge = cyc + 1;
        repeat (3) @(negedge clk);
        rx = 1'b1;
        while (cyc + 1 < e_edge + 2 + CPB / 2) @(negedge clk);
        check("glitch_busy_mid", 32'(busy), 1);
        @(negedge clk);
        check("glitch_busy_idle", 32'(busy), 0);
        drain("glitch_pending");

        // Framing error with line held low afterwards.
        send(8'h55, 1'b0, 1'b0, -1, 40, 1'b1);
        drain("ferr_pending");

        // Reset during data bit 4, then a clean frame.
        send(8'hA5, 1'b1, 1'b0, 4, 0, 1'b0);
        repeat (2 * CPB) @(negedge clk);
        send(8'h3C, 1'b1, 1'b0, -1, 0, 1'b1);
        drain("reset_pending");

`ifdef UART_RX_PARITY_EN
        send(8'h41, 1'b1, 1'b0, -1, 0, 1'b1);
        send(8'h41, 1'b1, 1'b1, -1, 0, 1'b1);
        rx = 1'b1;
        drain("parity_pending");
`endif

        repeat (20) @(negedge clk);
        check("final_queue", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
# uart_rx

Asynchronous serial receiver, the receive-side counterpart of `uart_tx`. It recovers 8N1 frames (optionally 8E1) from the `rx` line and samples each bit at mid-bit using a fixed clocks-per-bit count. Each good byte is presented on `data` with a one-cycle `valid` strobe. It sits between the board-level RX pin and the byte-consuming logic, and runs on the same clock and bit rate as `uart_tx`.

## Interface
- `CLKS_PER_BIT`, default 16: clock cycles per bit period; must be even and ≥ 4.
- `clk` input 1: system clock; all state changes on the rising edge.
- `rst` input 1: asynchronous, active-low reset.
- `rx` input 1: serial line; idle high; asynchronous to `clk`.
- `data` output 8: last good byte received, LSB first on the wire; holds until the next good byte.
- `valid` output 1: one-cycle pulse; `data` is new this cycle.
- `frame_err` output 1: one-cycle pulse; stop bit sampled low (or parity mismatch when parity is enabled).
- `busy` output 1: high whenever state ≠ IDLE.

## Operation
- **Input synchronizer.** `rx` passes through two flops to produce `rx_s`. Both flops reset to 1. All decisions use `rx_s` only.
- **Bit counter.** `cnt` counts 0..CLKS_PER_BIT-1 within a bit period. `bit_idx` counts 0..7.
- **IDLE.** On `rx_s`==0, go to START with `cnt`=0.
- **START.**
  - At `cnt`==CLKS_PER_BIT/2-1 (mid start bit), sample `rx_s`.
  - If 1: glitch, return to IDLE with no output.
  - If 0: go to DATA with `cnt`=0 and `bit_idx`=0.
- **DATA.**
  - At `cnt`==CLKS_PER_BIT-1, shift `rx_s` into the shift register MSB (so it becomes LSB-first), reset `cnt`, increment `bit_idx`.
  - After bit 7 is sampled, go to PARITY if enabled, else STOP.
- **PARITY** (only with the macro). At `cnt`==CLKS_PER_BIT-1, sample and store the parity bit, then go to STOP.
- **STOP.** At `cnt`==CLKS_PER_BIT-1, sample `rx_s`.
  - 1 and parity OK: load `data` from the shift register, pulse `valid`, go to IDLE.
  - Otherwise: pulse `frame_err`, leave `data` unchanged, go to BREAK.
- **BREAK.** Wait for `rx_s`==1, then go to IDLE. This prevents a held-low line from being re-read as start bits.
- **Outputs.** `valid` and `frame_err` are registered and never high in the same cycle.
- **Reset values.** `data`=8'h00, `valid`=0, `frame_err`=0, `busy`=0, state=IDLE.
- **Reset mid-frame.** The frame is discarded and no strobe is emitted. After reset releases, the receiver waits in IDLE for a fresh falling edge. If `rx` is already low at release, it is treated as a start bit.

## Timing
- **Edge detection.** Let E be the first rising edge at which `rx` is low at the first sync flop. `rx_s` is low at E+1, and START is entered at E+2.
- **Sample points.**
  - Mid start: E+2+CLKS_PER_BIT/2.
  - Data bit n: E+2+CLKS_PER_BIT/2+(n+1)·CLKS_PER_BIT.
  - Stop: E+2+CLKS_PER_BIT/2+9·CLKS_PER_BIT.
  - Parity, when enabled, shifts the stop sample by one more CLKS_PER_BIT.
- **Strobe latency.** `valid`/`frame_err` are high the cycle after the stop sample. For CLKS_PER_BIT=16: E+155 without parity, E+171 with parity.
- **Next frame.** IDLE is re-entered in the same cycle as the strobe. A start edge arriving immediately after the stop bit's midpoint is accepted, so back-to-back frames need no idle gap.
- **Tolerance.** Mid-bit sampling tolerates about ±4% cumulative baud mismatch.

## Configuration
- `UART_RX_PARITY_EN`
  - **Defined:** the frame is start + 8 data + 1 even-parity bit + stop (the PARITY state exists). A mismatch raises `frame_err` instead of `valid`, even when the stop bit is good.
  - **Undefined:** 8N1; there is no PARITY state and the parity logic is absent.

## Test plan
- **Single byte.** Drive 8'h41 as 8N1 at CLKS_PER_BIT=16 starting at edge E → `valid`=1 exactly at E+155 for one cycle, `data`=8'h41, `frame_err` never high, `busy` low at E+155.
- **Loopback.** Connect `uart_tx.tx`→`rx` and send 8'h41 then 8'h42 back-to-back with no idle gap → two `valid` pulses with `data` 8'h41 then 8'h42.
- **Glitch rejection.** Pull `rx` low for 3 cycles then high → no `valid`, no `frame_err`, back in IDLE by E+2+CLKS_PER_BIT/2+1.
- **Framing error.** Send 8'h55 with the stop bit forced to 0 and the line held low 40 cycles more → one `frame_err` pulse, `data` keeps its previous value, `busy` stays high until `rx` returns high, no spurious start.
- **Reset mid-frame.** Assert `rst` low during data bit 4 of 8'hA5 → all outputs at reset values immediately; no strobe after release; a following 8'h3C is received correctly.
- **Parity** (with `UART_RX_PARITY_EN`). 8'h41 with parity bit 0 → `valid`, `data`=8'h41. The same byte with parity bit 1 → `frame_err` at E+171.
